instr_mem_fetch: RTL

Parametrised, word-organised instruction memory with a program-load port and a registered fetch stage. After reset it accepts a program over a valid/ready load interface, then serves 32-bit little-endian instructions to the pipeline IF stage with one-cycle latency. It supports stalls, reports misaligned and out-of-range fetches, and drives a NOP into the pipeline whenever no valid instruction is available. It replaces the hard-coded combinational instruction ROM in front of the IF/ID register.

---
 rtl/imem_pkg.sv | 31 +++
 rtl/imem_array.sv | 41 ++++
 rtl/instr_mem_fetch.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction memory / fetch block:
//   - IMEM_WORD_W   : instruction word width (32 bits)
//   - IMEM_NOP_INSN : default bubble instruction (addi x0,x0,0)
//   - state_t       : LOAD / RUN state encoding of the fetch block FSM
//   - FAULT_*       : bit positions inside the 2-bit fault vector
//   - fault_vec()   : packs the two fault conditions into a fault vector
// -----------------------------------------------------------------------------
package imem_pkg;

    localparam int          IMEM_WORD_W   = 32;
    localparam logic [31:0] IMEM_NOP_INSN = 32'h0000_0013;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int FAULT_MISALIGN = 0;
    localparam int FAULT_RANGE    = 1;

    function automatic logic [1:0] fault_vec(input logic misalign, input logic range_err);
        logic [1:0] f;
        f                 = 2'b00;
        f[FAULT_MISALIGN] = misalign;
        f[FAULT_RANGE]    = range_err;
        return f;
    endfunction

endpackage

// File: rtl/imem_array.sv
// -----------------------------------------------------------------------------
// imem_array
// Storage-only word array: DEPTH_WORDS x 32 bits, one synchronous write port
// and one asynchronous read port. Contents are not reset.
//
// Ports:
//   clk      in   clock
//   we_i     in   write enable (one word per cycle)
//   waddr_i  in   write word index
//   wdata_i  in   write data; bits [7:0] are the byte at the lowest address
//   raddr_i  in   read word index
//   rdata_o  out  word at raddr_i (combinational)
// -----------------------------------------------------------------------------
module imem_array
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int LA_W        = $clog2(DEPTH_WORDS)
) (
    input  logic                   clk,
    input  logic                   we_i,
    input  logic [LA_W-1:0]        waddr_i,
    input  logic [IMEM_WORD_W-1:0] wdata_i,
    input  logic [LA_W-1:0]        raddr_i,
    output logic [IMEM_WORD_W-1:0] rdata_o
);

    logic [IMEM_WORD_W-1:0] mem_q [DEPTH_WORDS];

    // Words are stored exactly as presented: the little-endian byte order of
    // the loader matches the order the pipeline expects, so no swizzle.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // DEPTH_WORDS is a power of two, so every raddr_i value is in range.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_mem_fetch.sv
// -----------------------------------------------------------------------------
// instr_mem_fetch
// Loadable instruction memory with a registered fetch stage. After reset the
// block sits in LOAD and accepts program words; ld_done moves it to RUN where
// it serves 32-bit instructions one cycle after PC is sampled. A NOP is
// presented whenever no valid instruction is available.
//
// Load handshake: a beat transfers on a rising clk edge where ld_valid and
// ld_ready are both 1. ld_ready is 1 exactly while the FSM is in LOAD and does
// not depend on ld_valid. ld_done ends the load phase on the edge it is
// sampled in LOAD, with or without an accompanying ld_valid beat.
//
// Ports:
//   clk              in   rising-edge clock
//   reset            in   synchronous active-low reset
//   ld_valid         in   load word present
//   ld_ready         out  block accepts load words (LOAD state)
//   ld_addr          in   load word index
//   ld_data          in   load word
//   ld_done          in   end of load phase
//   ld_count         out  words accepted since reset, saturating at DEPTH_WORDS
//   loaded           out  1 in RUN
//   PC               in   byte address to fetch
//   fetch_en         in   request a fetch of PC
//   stall            in   hold all fetch outputs
//   Instruction_Code out  fetched instruction (NOP when not valid)
//   instr_valid      out  Instruction_Code is a real fetched word
//   instr_pc         out  PC that produced Instruction_Code
//   fault            out  bit0 misaligned, bit1 out of range
//   dbg_state_o      out  current FSM state (0 = LOAD, 1 = RUN)
// -----------------------------------------------------------------------------
module instr_mem_fetch
    import imem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter int          ADDR_W      = 32,
    parameter logic [31:0] NOP_INSN    = IMEM_NOP_INSN,
    localparam int         LA_W        = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    // program load port
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [LA_W-1:0]   ld_addr,
    input  logic [31:0]       ld_data,
    input  logic              ld_done,
    output logic [LA_W:0]     ld_count,
    output logic              loaded,
    // fetch port
    input  logic [ADDR_W-1:0] PC,
    input  logic              fetch_en,
    input  logic              stall,
    output logic [31:0]       Instruction_Code,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [1:0]        fault,
    // observability
    output logic              dbg_state_o
);

    localparam logic [LA_W:0]       COUNT_MAX  = (LA_W + 1)'(DEPTH_WORDS);
    localparam logic [ADDR_W-3:0]   WORD_LIMIT = (ADDR_W - 2)'(DEPTH_WORDS);

    // -------------------------------------------------------------------------
    // FSM, load counter and load-port status (all registered)
    // -------------------------------------------------------------------------
    state_t          state_q;
    logic            ld_ready_q;
    logic            loaded_q;
    logic [LA_W:0]   ld_count_q;
    logic            load_fire;

    assign load_fire = ld_valid & ld_ready_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= LOAD;
            ld_ready_q <= 1'b1;
            loaded_q   <= 1'b0;
            ld_count_q <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    // Rewrites of an address still count as accepted beats.
                    if (load_fire && (ld_count_q != COUNT_MAX)) begin
                        ld_count_q <= ld_count_q + 1'b1;
                    end
                    if (ld_done) begin
                        state_q    <= RUN;
                        ld_ready_q <= 1'b0;
                        loaded_q   <= 1'b1;
                    end
                end
                RUN: begin
                    // Load port is ignored until the next reset.
                end
                default: begin
                    state_q    <= LOAD;
                    ld_ready_q <= 1'b1;
                    loaded_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ld_ready    = ld_ready_q;
    assign loaded      = loaded_q;
    assign ld_count    = ld_count_q;
    assign dbg_state_o = (state_q == RUN);

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    logic              mem_we;
    logic [LA_W-1:0]   rd_addr;
    logic [31:0]       rd_data;

    // Gate with reset so a beat presented during reset is not stored.
    assign mem_we  = reset & load_fire;
    assign rd_addr = PC[LA_W+1:2];

    imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .LA_W        (LA_W)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (ld_addr),
        .wdata_i (ld_data),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    // -------------------------------------------------------------------------
    // Fault decode on the incoming PC
    // -------------------------------------------------------------------------
    logic [ADDR_W-3:0] pc_word;
    logic              pc_misalign;
    logic              pc_range;
    logic [1:0]        pc_fault;

    assign pc_word     = PC[ADDR_W-1:2];
    assign pc_misalign = |PC[1:0];
    assign pc_range    = (pc_word >= WORD_LIMIT);
    assign pc_fault    = fault_vec(pc_misalign, pc_range);

    // -------------------------------------------------------------------------
    // Fetch output registers
    // -------------------------------------------------------------------------
    logic [31:0]       insn_q,  insn_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] ipc_q,   ipc_d;
    logic [1:0]        fault_q, fault_d;

    always_comb begin
        insn_d  = insn_q;
        valid_d = valid_q;
        ipc_d   = ipc_q;
        fault_d = fault_q;
        if (state_q == LOAD) begin
            // Outputs stay at their reset values while the program loads.
            insn_d  = NOP_INSN;
            valid_d = 1'b0;
            ipc_d   = '0;
            fault_d = 2'b00;
        end else if (!stall) begin
            if (fetch_en) begin
                ipc_d   = PC;
                fault_d = pc_fault;
                if (pc_fault != 2'b00) begin
                    insn_d  = NOP_INSN;
                    valid_d = 1'b0;
                end else begin
                    insn_d  = rd_data;
                    valid_d = 1'b1;
                end
            end else begin
                // Bubble: instr_pc keeps the last fetched address.
                insn_d  = NOP_INSN;
                valid_d = 1'b0;
                fault_d = 2'b00;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            insn_q  <= NOP_INSN;
            valid_q <= 1'b0;
            ipc_q   <= '0;
            fault_q <= 2'b00;
        end else begin
            insn_q  <= insn_d;
            valid_q <= valid_d;
            ipc_q   <= ipc_d;
            fault_q <= fault_d;
        end
    end

    assign Instruction_Code = insn_q;
    assign instr_valid      = valid_q;
    assign instr_pc         = ipc_q;
    assign fault            = fault_q;

endmodule
